// File: rtl/rvfi_pc_chain_check.sv
// Windowed PC-continuity checker for a multi-channel RVFI bus: captures DEPTH consecutive
// orders from any channel in any order and checks pc_wdata(k) against pc_rdata(k+1).
module rvfi_pc_chain_check #(
    parameter int unsigned NRET      = 1,
    parameter int unsigned XLEN      = 32,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ADDR_BITS = 32,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   check,
    input  logic [63:0]            start_order,
    input  logic [NRET-1:0]        rvfi_valid,
    input  logic [64*NRET-1:0]     rvfi_order,
    input  logic [XLEN*NRET-1:0]   rvfi_pc_rdata,
    input  logic [XLEN*NRET-1:0]   rvfi_pc_wdata,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [1:0]             err_code,
    output logic [63:0]            err_order
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) + 1 : 1;

    localparam logic [1:0] CodeMismatch = 2'd1;
    localparam logic [1:0] CodeDup      = 2'd2;
    localparam logic [1:0] CodeTimeout  = 2'd3;

    typedef enum logic [1:0] {StIdle, StTrack, StDone, StFail} state_e;

    state_e                state_q, state_d;
    logic [63:0]           start_q, start_d;
    logic [DEPTH-1:0]      slot_v_q, slot_v_d;
    logic [ADDR_BITS-1:0]  pc_r_q [DEPTH];
    logic [ADDR_BITS-1:0]  pc_r_d [DEPTH];
    logic [ADDR_BITS-1:0]  pc_w_q [DEPTH];
    logic [ADDR_BITS-1:0]  pc_w_d [DEPTH];
    logic [TW-1:0]         timer_q, timer_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [1:0]            code_q, code_d;
    logic [63:0]           order_q, order_d;

    logic                  mm_any;
    logic [IW-1:0]         mm_idx;
    logic [63:0]           idx;
    logic [IW-1:0]         slot;
    logic [DEPTH-1:0]      claim;
    logic [DEPTH-1:0]      dup_hit;
    logic [IW-1:0]         dup_idx;

    // Lowest failing pair wins, so scan downwards and let later hits overwrite.
    always_comb begin
        mm_any = 1'b0;
        mm_idx = '0;
        for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
            if (slot_v_q[i] && slot_v_q[i+1] && (pc_w_q[i] != pc_r_q[i+1])) begin
                mm_any = 1'b1;
                mm_idx = IW'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        start_d  = start_q;
        slot_v_d = slot_v_q;
        pc_r_d   = pc_r_q;
        pc_w_d   = pc_w_q;
        timer_d  = timer_q;
        done_d   = done_q;
        err_d    = err_q;
        code_d   = code_q;
        order_d  = order_q;
        idx      = '0;
        slot     = '0;
        claim    = '0;
        dup_hit  = '0;
        dup_idx  = '0;

        unique case (state_q)
            StIdle, StDone, StFail: begin
                if (check) begin
                    start_d  = start_order;
                    slot_v_d = '0;
                    timer_d  = '0;
                    done_d   = 1'b0;
                    err_d    = 1'b0;
                    code_d   = 2'd0;
                    order_d  = '0;
                    state_d  = StTrack;
                end
            end
            StTrack: begin
                // Lower channels claim a slot first; a later hit on the same slot is a dup.
                for (int c = 0; c < int'(NRET); c++) begin
                    if (rvfi_valid[c]) begin
                        idx = rvfi_order[64*c +: 64] - start_q;
                        if (idx < 64'(DEPTH)) begin
                            slot = idx[IW-1:0];
                            if (slot_v_q[slot] || claim[slot]) begin
                                dup_hit[slot] = 1'b1;
                            end else begin
                                claim[slot]  = 1'b1;
                                pc_r_d[slot] = rvfi_pc_rdata[XLEN*c +: ADDR_BITS];
                                pc_w_d[slot] = rvfi_pc_wdata[XLEN*c +: ADDR_BITS];
                            end
                        end
                    end
                end
                slot_v_d = slot_v_q | claim;

                for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
                    if (dup_hit[i]) dup_idx = IW'(i);
                end

                if (timer_q != '1) timer_d = timer_q + TW'(1);

                if (|dup_hit) begin
                    err_d   = 1'b1;
                    code_d  = CodeDup;
                    order_d = start_q + 64'(dup_idx);
                    state_d = StFail;
                end else if (mm_any) begin
                    err_d   = 1'b1;
                    code_d  = CodeMismatch;
                    order_d = start_q + 64'(mm_idx);
                    state_d = StFail;
                end else if (&slot_v_q) begin
                    done_d  = 1'b1;
                    state_d = StDone;
                end else if ((TIMEOUT != 0) && (timer_q == TW'(TIMEOUT - 1))) begin
                    err_d   = 1'b1;
                    code_d  = CodeTimeout;
                    order_d = '0;
                    state_d = StFail;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            start_q  <= '0;
            slot_v_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_r_q[i] <= '0;
                pc_w_q[i] <= '0;
            end
            timer_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= 2'd0;
            order_q  <= '0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            slot_v_q <= slot_v_d;
            pc_r_q   <= pc_r_d;
            pc_w_q   <= pc_w_d;
            timer_q  <= timer_d;
            done_q   <= done_d;
            err_q    <= err_d;
            code_q   <= code_d;
            order_q  <= order_d;
        end
    end

    assign busy      = (state_q == StTrack);
    assign done      = done_q;
    assign err       = err_q;
    assign err_code  = code_q;
    assign err_order = order_q;

endmodule

// File: tb/tb_rvfi_pc_chain_check.sv
// Scoreboard bench for rvfi_pc_chain_check: each window's outcome and TRACK length are
// predicted from per-slot arrival times and compared when the checker leaves TRACK.
module tb_rvfi_pc_chain_check;

    localparam int unsigned NRET      = 2;
    localparam int unsigned XLEN      = 32;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned ADDR_BITS = 16;
    localparam int unsigned TO        = 12;
    localparam logic [31:0] MASK      = 32'h0000_FFFF;
    localparam int          INF       = 1000;
    localparam int          MAXB      = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          check = 1'b0;
    logic [63:0]   start_order = '0;
    logic [1:0]    rvfi_valid = '0;
    logic [127:0]  rvfi_order = '0;
    logic [63:0]   rvfi_pc_rdata = '0;
    logic [63:0]   rvfi_pc_wdata = '0;
    logic          busy, done, err;
    logic [1:0]    err_code;
    logic [63:0]   err_order;

    rvfi_pc_chain_check #(
        .NRET(NRET), .XLEN(XLEN), .DEPTH(DEPTH), .ADDR_BITS(ADDR_BITS), .TIMEOUT(TO)
    ) dut (
        .clock(clock), .reset(reset), .check(check), .start_order(start_order),
        .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
        .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
        .busy(busy), .done(done), .err(err), .err_code(err_code), .err_order(err_order)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        done;
        logic        err;
        logic [1:0]  code;
        logic [63:0] order;
        int          cycles;
    } exp_t;

    exp_t exp_q[$];
    int n_checks = 0;
    int n_fail = 0;

    // One window of stimulus: beat t is presented in the t-th TRACK cycle.
    logic        bv [MAXB][2];
    logic [63:0] bo [MAXB][2];
    logic [31:0] br [MAXB][2];
    logic [31:0] bw [MAXB][2];
    int          nb;
    logic [63:0] win_s;

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic clear_beats();
        for (int t = 0; t < MAXB; t++) begin
            for (int c = 0; c < 2; c++) begin
                bv[t][c] = 1'b0;
                bo[t][c] = '0;
                br[t][c] = '0;
                bw[t][c] = '0;
            end
        end
        nb = 0;
    endtask

    task automatic add(input int t, input int c, input logic [63:0] o,
                       input logic [31:0] r, input logic [31:0] w);
        bv[t][c] = 1'b1;
        bo[t][c] = o;
        br[t][c] = r;
        bw[t][c] = w;
        if (t + 1 > nb) nb = t + 1;
    endtask

    task automatic place(input logic [63:0] o, input logic [31:0] r, input logic [31:0] w);
        bit placed = 1'b0;
        for (int t = int'($urandom_range(0, 4)); t < MAXB && !placed; t++) begin
            for (int c = 0; c < 2 && !placed; c++) begin
                if (!bv[t][c]) begin
                    add(t, c, o, r, w);
                    placed = 1'b1;
                end
            end
        end
    endtask

    // Outcome from per-slot first-arrival and second-arrival times: each event becomes
    // visible at a known cycle, the earliest wins, ties by priority dup > pair > done > timeout.
    function automatic exp_t model();
        exp_t        e;
        int          cap_t [DEPTH];
        int          dup_t [DEPTH];
        logic [31:0] cr [DEPTH];
        logic [31:0] cw [DEPTH];
        int          mm_t [DEPTH];
        int          done_t;
        int          tmin;
        logic [63:0] d;
        int          k;
        for (int i = 0; i < DEPTH; i++) begin
            cap_t[i] = INF;
            dup_t[i] = INF;
            mm_t[i]  = INF;
            cr[i]    = '0;
            cw[i]    = '0;
        end
        for (int t = 0; t < nb; t++) begin
            for (int c = 0; c < 2; c++) begin
                if (bv[t][c]) begin
                    d = bo[t][c] - win_s;
                    if (d < 64'(DEPTH)) begin
                        k = int'(d);
                        if (cap_t[k] == INF) begin
                            cap_t[k] = t;
                            cr[k] = br[t][c];
                            cw[k] = bw[t][c];
                        end else if (dup_t[k] == INF) begin
                            dup_t[k] = t;
                        end
                    end
                end
            end
        end
        done_t = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (cap_t[i] == INF) done_t = INF;
            else if (done_t != INF && cap_t[i] + 1 > done_t) done_t = cap_t[i] + 1;
        end
        for (int i = 0; i + 1 < DEPTH; i++) begin
            if (cap_t[i] != INF && cap_t[i+1] != INF && ((cw[i] ^ cr[i+1]) & MASK) != 0)
                mm_t[i] = ((cap_t[i] > cap_t[i+1]) ? cap_t[i] : cap_t[i+1]) + 1;
        end
        tmin = TO - 1;
        if (done_t < tmin) tmin = done_t;
        for (int i = 0; i < DEPTH; i++) begin
            if (dup_t[i] < tmin) tmin = dup_t[i];
            if (mm_t[i] < tmin) tmin = mm_t[i];
        end
        e.done = 1'b0; e.err = 1'b1; e.code = 2'd3; e.order = '0;
        if (done_t == tmin) begin
            e.done = 1'b1; e.err = 1'b0; e.code = 2'd0; e.order = '0;
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (mm_t[i] == tmin) begin
                e.done = 1'b0; e.err = 1'b1; e.code = 2'd1; e.order = win_s + 64'(i);
            end
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (dup_t[i] == tmin) begin
                e.done = 1'b0; e.err = 1'b1; e.code = 2'd2; e.order = win_s + 64'(i);
            end
        end
        e.cycles = tmin + 1;
        return e;
    endfunction

    task automatic drive_beat(input int t);
        rvfi_valid    = {bv[t][1], bv[t][0]};
        rvfi_order    = {bo[t][1], bo[t][0]};
        rvfi_pc_rdata = {br[t][1], br[t][0]};
        rvfi_pc_wdata = {bw[t][1], bw[t][0]};
    endtask

    task automatic drive_idle();
        rvfi_valid    = '0;
        rvfi_order    = '0;
        rvfi_pc_rdata = '0;
        rvfi_pc_wdata = '0;
    endtask

    task automatic run_window(input bit junk, input bit reset_mid);
        int n;
        if (!reset_mid) exp_q.push_back(model());
        @(negedge clock);
        check = 1'b1;
        start_order = win_s;
        drive_idle();
        if (junk) begin
            // Retirement in the arm cycle must not be captured.
            rvfi_valid = 2'b01;
            rvfi_order[63:0] = win_s;
            rvfi_pc_rdata[31:0] = $urandom;
            rvfi_pc_wdata[31:0] = $urandom;
        end
        @(negedge clock);
        check = 1'b0;
        check_eq("arm_status", 64'({busy, done, err, err_code}), 64'b10000);
        for (int t = 0; t < nb; t++) begin
            drive_beat(t);
            if (reset_mid && t == 1) begin
                #2 reset = 1'b1;
                #1 check_eq("reset_async", 64'({busy, done, err, err_code}) | err_order, 64'd0);
                drive_idle();
                repeat (2) @(negedge clock);
                reset = 1'b0;
                return;
            end
            @(negedge clock);
        end
        drive_idle();
        n = 0;
        while (busy && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_bound: busy still 1 after 40 idle cycles, expected 0");
            reset = 1'b1;
            repeat (2) @(negedge clock);
            reset = 1'b0;
            exp_q.delete();
        end
    endtask

    task automatic gen_random();
        logic [31:0] pc [DEPTH+1];
        logic [31:0] rr [DEPTH];
        logic [31:0] ww [DEPTH];
        int mode;
        int pick;
        clear_beats();
        if ($urandom_range(0, 3) == 0) win_s = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 5));
        else win_s = {$urandom, $urandom};
        pc[0] = $urandom & 32'hFFFF_FFFC;
        for (int k2 = 0; k2 < DEPTH; k2++)
            pc[k2+1] = ($urandom_range(0, 2) == 0) ? ($urandom & 32'hFFFF_FFFC) : pc[k2] + 32'd4;
        for (int k2 = 0; k2 < DEPTH; k2++) begin
            rr[k2] = pc[k2];
            ww[k2] = pc[k2+1];
        end
        mode = int'($urandom_range(0, 9));
        pick = int'($urandom_range(1, DEPTH - 1));
        if (mode <= 1) rr[pick] = rr[pick] ^ (32'd1 << $urandom_range(0, 15));
        if (mode == 2) rr[pick] = rr[pick] ^ (32'd1 << $urandom_range(16, 31));
        for (int k2 = 0; k2 < DEPTH; k2++)
            if (!(mode == 4 && k2 == pick)) place(win_s + 64'(k2), rr[k2], ww[k2]);
        if (mode == 3) place(win_s + 64'($urandom_range(0, DEPTH - 1)), $urandom, $urandom);
        if ($urandom_range(0, 1) == 1) begin
            if ($urandom_range(0, 1) == 1) place(win_s + 64'(DEPTH + $urandom_range(0, 100)),
                                                 $urandom, $urandom);
            else place(win_s - 64'd1 - 64'($urandom_range(0, 100)), $urandom, $urandom);
        end
    endtask

    // Monitor: counts TRACK cycles and scores each exit from TRACK against the queue.
    initial begin
        int   cnt;
        logic prev;
        exp_t e;
        cnt = 0;
        prev = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                cnt = 0;
                prev = 1'b0;
            end else begin
                if (busy) begin
                    cnt++;
                end else if (prev) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_outcome: done=%0d err=%0d, expected none",
                                 done, err);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("status", 64'({done, err, err_code}), 64'({e.done, e.err, e.code}));
                        check_eq("err_order", err_order, e.order);
                        check_eq("track_cycles", 64'(cnt), 64'(e.cycles));
                    end
                    cnt = 0;
                end
                prev = busy;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clock);
        check_eq("reset_state", 64'({busy, done, err, err_code}) | err_order, 64'd0);
        reset = 1'b0;

        // Sequential single-channel window.
        clear_beats(); win_s = 64'd10;
        add(0, 0, 64'd10, 32'h100, 32'h104); add(1, 0, 64'd11, 32'h104, 32'h108);
        add(2, 0, 64'd12, 32'h108, 32'h10C); add(3, 0, 64'd13, 32'h10C, 32'h110);
        run_window(1'b1, 1'b0);

        // Two channels, reversed order within each beat.
        clear_beats();
        add(0, 0, 64'd11, 32'h104, 32'h108); add(0, 1, 64'd10, 32'h100, 32'h104);
        add(1, 0, 64'd13, 32'h10C, 32'h110); add(1, 1, 64'd12, 32'h108, 32'h10C);
        run_window(1'b0, 1'b0);

        // Broken link between orders 11 and 12.
        clear_beats();
        add(0, 0, 64'd10, 32'h100, 32'h104); add(1, 0, 64'd11, 32'h104, 32'h108);
        add(2, 0, 64'd12, 32'h200, 32'h204); add(3, 0, 64'd13, 32'h204, 32'h208);
        run_window(1'b0, 1'b0);

        // Same order on both channels in one cycle.
        clear_beats();
        add(0, 0, 64'd11, 32'h104, 32'h108); add(0, 1, 64'd11, 32'h104, 32'h108);
        add(1, 0, 64'd10, 32'h100, 32'h104);
        run_window(1'b0, 1'b0);

        // Incomplete window times out; the following arm clears status.
        clear_beats();
        add(0, 0, 64'd10, 32'h100, 32'h104); add(1, 0, 64'd11, 32'h104, 32'h108);
        run_window(1'b0, 1'b0);

        // Window straddling order wrap-around.
        clear_beats(); win_s = 64'hFFFF_FFFF_FFFF_FFFE;
        add(0, 0, 64'hFFFF_FFFF_FFFF_FFFE, 32'h400, 32'h404);
        add(0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 32'h404, 32'h408);
        add(1, 1, 64'd0, 32'h408, 32'h40C); add(2, 0, 64'd1, 32'h40C, 32'h410);
        run_window(1'b0, 1'b0);

        // Upper PC bits differ across every link; only the low 16 bits are compared.
        clear_beats(); win_s = 64'd100;
        add(0, 0, 64'd100, 32'h1111_0100, 32'h2222_0104);
        add(0, 1, 64'd101, 32'h3333_0104, 32'h4444_0108);
        add(1, 0, 64'd102, 32'h5555_0108, 32'h6666_010C);
        add(1, 1, 64'd103, 32'h7777_010C, 32'h8888_0110);
        run_window(1'b0, 1'b0);

        // Reset in the middle of TRACK.
        clear_beats(); win_s = 64'd10;
        add(0, 0, 64'd10, 32'h100, 32'h104); add(1, 0, 64'd11, 32'h104, 32'h108);
        add(2, 0, 64'd12, 32'h108, 32'h10C);
        run_window(1'b0, 1'b1);

        for (int i = 0; i < 60; i++) begin
            gen_random();
            run_window(($urandom_range(0, 3) == 0), 1'b0);
        end

        repeat (4) @(negedge clock);
        check_eq("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
